// File: rtl/rb_fifo_gen_if.sv
// Producer/consumer-facing bundle of the rb_fifo_gen ring-buffer FIFO.
// master drives requests and data; slave is the FIFO itself.
interface rb_fifo_gen_if #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic [WIDTH-1:0]    dataIn;
  logic                push;
  logic                pop;
  logic                clr_err;
  logic [WIDTH-1:0]    dataOut;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                underflow;

  modport master (
    output dataIn, push, pop, clr_err,
    input  dataOut, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  dataIn, push, pop, clr_err,
    output dataOut, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/rb_fifo_gen.sv
// Parametrised single-clock ring-buffer FIFO with occupancy count, watermark flags,
// sticky overflow/underflow and a registered head-of-queue output.
module rb_fifo_gen #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AF_LEVEL   = (2 ** DEPTH_LOG2) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input logic          clock,
  input logic          rst,
  rb_fifo_gen_if.slave fifo_if
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]         DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0]         AfCnt    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]         AeCnt    = CW'(AE_LEVEL);
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = DEPTH_LOG2'(1);

  if (WIDTH < 1 || DEPTH_LOG2 < 1) begin : gen_bad_size
    $error("rb_fifo_gen: WIDTH and DEPTH_LOG2 must be at least 1");
  end
  if (!(AE_LEVEL >= 1 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : gen_bad_levels
    $error("rb_fifo_gen: require 1 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] head_q, head_d;
  logic [DEPTH_LOG2-1:0] tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WIDTH-1:0]      dout_q, dout_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty;
  logic                  push_ok, pop_ok;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  always_comb begin
    pop_ok      = fifo_if.pop & ~empty;
    // A push on full only fits if the same cycle frees the head slot.
    push_ok     = fifo_if.push & (~full | fifo_if.pop);
    head_d      = pop_ok  ? head_q + PtrOne : head_q;
    tail_d      = push_ok ? tail_q + PtrOne : tail_q;
    count_d     = count_q + CW'(push_ok) - CW'(pop_ok);

    dout_d = dout_q;
    if (count_d != '0) begin
      // Bypass: the slot that becomes head is being written this very edge.
      if (push_ok && (tail_q == head_d)) begin
        dout_d = fifo_if.dataIn;
      end else begin
        dout_d = mem_q[head_d];
      end
    end

    overflow_d  = fifo_if.clr_err ? 1'b0 : overflow_q;
    underflow_d = fifo_if.clr_err ? 1'b0 : underflow_q;
    if (fifo_if.push && !push_ok) overflow_d  = 1'b1;
    if (fifo_if.pop  && !pop_ok)  underflow_d = 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[tail_q] <= fifo_if.dataIn;
    end
  end

  assign fifo_if.dataOut      = dout_q;
  assign fifo_if.full         = full;
  assign fifo_if.empty        = empty;
  assign fifo_if.almost_full  = (count_q >= AfCnt);
  assign fifo_if.almost_empty = (count_q <= AeCnt);
  assign fifo_if.count        = count_q;
  assign fifo_if.overflow     = overflow_q;
  assign fifo_if.underflow    = underflow_q;
endmodule

// File: tb/tb_rb_fifo_gen.sv
// Self-checking bench for rb_fifo_gen at default parameters: vector table for the fill,
// scoreboard queue for data order, hand sequences for reset, wrap, bypass and error flags.
module tb_rb_fifo_gen;
  logic clock = 1'b0;
  logic rst   = 1'b1;

  rb_fifo_gen_if #(.WIDTH(4), .DEPTH_LOG2(4)) bus ();

  rb_fifo_gen #(
    .WIDTH     (4),
    .DEPTH_LOG2(4),
    .AF_LEVEL  (14),
    .AE_LEVEL  (2)
  ) dut (
    .clock  (clock),
    .rst    (rst),
    .fifo_if(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic [3:0] din;
    int         exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_af;
    logic       exp_ae;
    logic       exp_ovf;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] sb[$];
  logic [3:0] pop_log[$];
  logic [3:0] last_out = 4'h0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  vec_t       vecs[18];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, int'(bus.count), 0);
    check({tag, "_empty"}, int'(bus.empty), 1);
    check({tag, "_full"}, int'(bus.full), 0);
    check({tag, "_ae"}, int'(bus.almost_empty), 1);
    check({tag, "_af"}, int'(bus.almost_full), 0);
    check({tag, "_dout"}, int'(bus.dataOut), 0);
    check({tag, "_ovf"}, int'(bus.overflow), 0);
    check({tag, "_unf"}, int'(bus.underflow), 0);
  endtask

  task automatic model_reset();
    sb.delete();
    last_out = 4'h0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  // One clock cycle of stimulus; the scoreboard predicts data, count and flags.
  task automatic step(input logic p, input logic q, input logic [3:0] d, input logic c);
    logic [3:0] pre;
    logic [3:0] exp_word;
    logic       m_push_ok;
    logic       m_pop_ok;
    int         n;
    @(negedge clock);
    bus.push    = p;
    bus.pop     = q;
    bus.dataIn  = d;
    bus.clr_err = c;
    m_pop_ok  = q && (sb.size() != 0);
    m_push_ok = p && ((sb.size() < 16) || q);
    pre = bus.dataOut;
    @(posedge clock);
    #1;
    if (m_pop_ok) begin
      exp_word = sb.pop_front();
      pop_log.push_back(pre);
      check("pop_data", int'(pre), int'(exp_word));
    end
    if (m_push_ok) sb.push_back(d);
    m_ovf = (c ? 1'b0 : m_ovf) | (p & ~m_push_ok);
    m_unf = (c ? 1'b0 : m_unf) | (q & ~m_pop_ok);
    if (sb.size() != 0) last_out = sb[0];
    n = sb.size();
    check("sb_count", int'(bus.count), n);
    check("sb_dout", int'(bus.dataOut), int'(last_out));
    check("sb_full", int'(bus.full), int'(n == 16));
    check("sb_empty", int'(bus.empty), int'(n == 0));
    check("sb_af", int'(bus.almost_full), int'(n >= 14));
    check("sb_ae", int'(bus.almost_empty), int'(n <= 2));
    check("sb_ovf", int'(bus.overflow), int'(m_ovf));
    check("sb_unf", int'(bus.underflow), int'(m_unf));
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_pops[20];

    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    bus.dataIn  = 4'h0;

    // Fill sequence: push 1..F,0, a rejected 17th push, then clr_err.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{push: 1'b1, pop: 1'b0, clr: 1'b0, din: 4'((i + 1) % 16),
                  exp_count: i + 1, exp_full: (i + 1 == 16), exp_empty: 1'b0,
                  exp_af: (i + 1 >= 14), exp_ae: (i + 1 <= 2), exp_ovf: 1'b0};
    end
    vecs[16] = '{push: 1'b1, pop: 1'b0, clr: 1'b0, din: 4'h7, exp_count: 16,
                 exp_full: 1'b1, exp_empty: 1'b0, exp_af: 1'b1, exp_ae: 1'b0, exp_ovf: 1'b1};
    vecs[17] = '{push: 1'b0, pop: 1'b0, clr: 1'b1, din: 4'h0, exp_count: 16,
                 exp_full: 1'b1, exp_empty: 1'b0, exp_af: 1'b1, exp_ae: 1'b0, exp_ovf: 1'b0};

    // Reset state is visible before any clock edge.
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 4'h0, 1'b0);

    // Mid-fill asynchronous reset at count 7 with underflow set.
    step(1'b0, 1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'(i + 3), 1'b0);
    check("midfill_count", int'(bus.count), 7);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clock);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
      check($sformatf("vec%0d_count", i), int'(bus.count), vecs[i].exp_count);
      check($sformatf("vec%0d_full", i), int'(bus.full), int'(vecs[i].exp_full));
      check($sformatf("vec%0d_empty", i), int'(bus.empty), int'(vecs[i].exp_empty));
      check($sformatf("vec%0d_af", i), int'(bus.almost_full), int'(vecs[i].exp_af));
      check($sformatf("vec%0d_ae", i), int'(bus.almost_empty), int'(vecs[i].exp_ae));
      check($sformatf("vec%0d_ovf", i), int'(bus.overflow), int'(vecs[i].exp_ovf));
    end

    // Full-rate push+pop at full for 20 cycles, wrapping both pointers.
    for (int i = 0; i < 20; i++) exp_pops[i] = (i < 16) ? 4'((i + 1) % 16) : 4'hA;
    pop_log.delete();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 4'hA, 1'b0);
      check("wrap_count", int'(bus.count), 16);
    end
    check("wrap_npops", pop_log.size(), 20);
    for (int i = 0; i < 20 && i < pop_log.size(); i++) begin
      check($sformatf("wrap_pop%0d", i), int'(pop_log[i]), int'(exp_pops[i]));
    end

    // Drain to empty; dataOut must then hold the last word.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'h0, 1'b0);
    check("drain_empty", int'(bus.empty), 1);
    check("drain_hold", int'(bus.dataOut), 10);

    // Push+pop on empty: push accepted via bypass, pop rejected.
    step(1'b1, 1'b1, 4'h5, 1'b0);
    check("pp_empty_count", int'(bus.count), 1);
    check("pp_empty_dout", int'(bus.dataOut), 5);
    check("pp_empty_unf", int'(bus.underflow), 1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("clr_unf", int'(bus.underflow), 0);

    // Count 1 holding 0x3, then push 0x9 + pop.
    step(1'b0, 1'b1, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h3, 1'b0);
    check("one_dout", int'(bus.dataOut), 3);
    step(1'b1, 1'b1, 4'h9, 1'b0);
    check("pp_one_count", int'(bus.count), 1);
    check("pp_one_dout", int'(bus.dataOut), 9);

    // Pop on empty together with clr_err: set wins, then a lone clear.
    step(1'b0, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b1);
    check("setwins_unf", int'(bus.underflow), 1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check("clr_only_unf", int'(bus.underflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rb_fifo_gen.md
# rb_fifo_gen

Parametrised ring-buffer FIFO, the next generation of the 4-bit × 16-entry ring-buffer FIFO. It generalises data width and depth and supports a true simultaneous push+pop. It adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags with software clear. It sits between producer and consumer datapaths in the same clock domain as a drop-in replacement where occupancy and flow-control watermarks are needed.

## Interface
- WIDTH, 4, data word width in bits (≥1)
- DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (≥1)
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- Constraint: 1 ≤ AE_LEVEL < AF_LEVEL ≤ DEPTH; violation is an elaboration error

Ports:
- clock  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- dataIn  in  WIDTH  word to enqueue
- push  in  1  enqueue request
- pop  in  1  dequeue request
- clr_err  in  1  clears overflow/underflow
- dataOut  out  WIDTH  head-of-queue word, registered
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

## Operation
- Storage: DEPTH × WIDTH array. Storage is not reset; its contents are unobservable until written.
- head and tail are each DEPTH_LOG2 bits and wrap modulo DEPTH by natural overflow. count is tracked separately, so full and empty never depend on pointer equality.
- pop_ok = pop & ~empty.
- push_ok = push & (~full | pop). A push on full is accepted only together with a pop. Both pointers advance and count stays DEPTH.
- push_ok writes mem[tail] ← dataIn and increments tail.
- pop_ok increments head.
- count_next = count + push_ok − pop_ok.
- Push+pop on empty: the pop is rejected and flags underflow. The push is accepted, and count becomes 1.
- full, empty, almost_full and almost_empty are pure decodes of the count register. They are glitch-free and valid in the same cycle as count.
- dataOut is registered and equals mem[head_next] after every edge.
  - Write-bypass: when push_ok writes the slot at head_next in the same cycle, dataOut takes dataIn. This covers a push into an empty FIFO and a push+pop with count == 1.
  - When the FIFO is empty, dataOut holds its previous value.
- Error flags:
  - overflow sets on push & ~push_ok.
  - underflow sets on pop & ~pop_ok.
  - clr_err clears both flags. A set in the same cycle as clr_err wins.
- Reset (asynchronous, any time, including mid-transfer):
  - head=0, tail=0, count=0, dataOut=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0.
  - All state takes these values immediately on rst assertion.
  - First operation is accepted on the first posedge after rst deasserts.

## Timing
- All outputs are registered or decode registered state; no combinational path from inputs to outputs.
- Push-to-visible latency: a word pushed into an empty FIFO at edge N appears on dataOut with empty=0 after edge N.
- Pop latency: the next word is on dataOut after the same edge that consumes the pop.
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH.
- The error flag is visible the cycle after the offending request.
- clr_err takes effect at the next edge.

## Test plan
Scenarios use defaults (WIDTH=4, DEPTH=16, AF=14, AE=2).
- Reset then idle -> count=0, empty=1, almost_empty=1, full=0, dataOut=0, no error flags. Assert rst mid-fill at count=7 -> all outputs return to reset values immediately, before the next edge.
- Push 0x1..0xF, 0x0 (16 words) -> count steps 1..16:
  - almost_empty deasserts at count=3.
  - almost_full asserts at count=14.
  - full asserts at count=16.
  - A 17th push -> count stays 16 and overflow=1.
  - clr_err -> overflow=0.
- From full, push 0xA + pop together for 20 cycles -> count stays 16, and dataOut pops 0x1..0xF, 0x0, then 0xA ×4 in order. This exercises wrap-around.
- From empty, push 0x5 + pop together -> count=1, underflow=1, dataOut=0x5 after the edge (bypass).
- Count=1 holding 0x3; push 0x9 + pop together -> count=1, dataOut=0x9.
- Pop on empty with clr_err in the same cycle -> underflow=1 (set wins). clr_err alone next cycle -> underflow=0.
